block_select_buffer: RTL and testbench

BLOCK_SELECT_BUFFER -- requirements
Module: block_select_buffer

---
 rtl/LDPC_pkg.sv | 21 ++
 rtl/block_lane_reg.sv | 26 ++
 rtl/block_select_buffer.sv | 131 +++++++++++++
 tb/tb_block_select_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/LDPC_pkg.sv
// rtl/LDPC_pkg.sv - shared LDPC sizing constants, lane-count helpers and buffer FSM states
package LDPC_pkg;

    localparam int MAX_ZC     = 384;
    localparam int MAX_LANES  = 23;

    function automatic int lane_cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    localparam int LANE_CNT_W = $clog2(MAX_LANES + 1);
    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUTPUT = 2'd3
    } bsb_state_t;

endpackage

// File: rtl/block_lane_reg.sv
// rtl/block_lane_reg.sv - one stored Zc-block; write-enabled, sourced from message or parity data
module block_lane_reg
    import LDPC_pkg::*;
#(
    parameter int WIDTH = MAX_ZC
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_sel_par,
    input  logic [WIDTH-1:0] i_msg,
    input  logic [WIDTH-1:0] i_par,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Pure datapath storage; contents are always rewritten before being observed.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_q <= i_sel_par ? i_par : i_msg;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/block_select_buffer.sv
// rtl/block_select_buffer.sv - lane buffer: load message blocks, apply selective parity updates, emit snapshot
module block_select_buffer
    import LDPC_pkg::*;
#(
    parameter  int LANES = 23,
    parameter  int WIDTH = MAX_ZC,
    localparam int LW    = lane_cnt_w(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LW-1:0]          lanes_active,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [WIDTH-1:0]       msg_data,
    input  logic                   par_valid,
    output logic                   par_ready,
    input  logic [LANES*WIDTH-1:0] par_data,
    input  logic [LANES-1:0]       par_sel,
    input  logic                   par_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_blocks,
    output logic                   busy,
    output logic                   err
);

    bsb_state_t             r_state;
    logic [LW-1:0]          r_cnt;
    logic [LW-1:0]          r_lanes;
    logic                   r_err;
    logic [LANES*WIDTH-1:0] r_out;

    logic [LANES*WIDTH-1:0] w_store;
    logic [LANES*WIDTH-1:0] w_out_next;
    logic [LANES-1:0]       w_active;
    logic [LANES-1:0]       w_msg_we;
    logic [LANES-1:0]       w_par_we;
    logic                   w_msg_acc;
    logic                   w_par_acc;
    logic                   w_start_ok;
    logic                   w_oob;

    assign w_msg_acc  = (r_state == ST_LOAD) && msg_valid;
    assign w_par_acc  = (r_state == ST_UPDATE) && par_valid;
    assign w_start_ok = (lanes_active != '0) && (lanes_active <= LW'(LANES));
    assign w_oob      = |(par_sel & ~w_active);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_active[gi] = r_lanes > LW'(gi);
            assign w_msg_we[gi] = w_msg_acc && (r_cnt == LW'(gi));
            assign w_par_we[gi] = w_par_acc && par_sel[gi] && w_active[gi];

            block_lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk       (clk),
                .i_we      (w_msg_we[gi] | w_par_we[gi]),
                .i_sel_par (w_par_we[gi]),
                .i_msg     (msg_data),
                .i_par     (par_data[gi*WIDTH +: WIDTH]),
                .o_q       (w_store[gi*WIDTH +: WIDTH])
            );

            // Snapshot sees this cycle's update so the result is ready one edge after par_last.
            assign w_out_next[gi*WIDTH +: WIDTH] =
                !w_active[gi] ? '0 :
                w_par_we[gi]  ? par_data[gi*WIDTH +: WIDTH] :
                                w_store[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lanes <= '0;
            r_err   <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_lanes <= lanes_active;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (msg_valid) begin
                        if (r_cnt == r_lanes - LW'(1)) begin
                            r_state <= ST_UPDATE;
                        end else begin
                            r_cnt <= r_cnt + LW'(1);
                        end
                    end
                end
                ST_UPDATE: begin
                    if (par_valid) begin
                        if (w_oob) begin
                            r_err <= 1'b1;
                        end
                        if (par_last) begin
                            r_out   <= w_out_next;
                            r_state <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign msg_ready  = (r_state == ST_LOAD);
    assign par_ready  = (r_state == ST_UPDATE);
    assign out_valid  = (r_state == ST_OUTPUT);
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;
    assign out_blocks = r_out;

endmodule

// File: tb/tb_block_select_buffer.sv
// tb/tb_block_select_buffer.sv - randomized self-checking bench for block_select_buffer
module tb_block_select_buffer;

    localparam int LANES = 23;
    localparam int WIDTH = 384;
    localparam int LW    = $clog2(LANES + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [LW-1:0]          lanes_active = '0;
    logic                   msg_valid = 1'b0;
    logic                   msg_ready;
    logic [WIDTH-1:0]       msg_data = '0;
    logic                   par_valid = 1'b0;
    logic                   par_ready;
    logic [LANES*WIDTH-1:0] par_data = '0;
    logic [LANES-1:0]       par_sel = '0;
    logic                   par_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES*WIDTH-1:0] out_blocks;
    logic                   busy;
    logic                   err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain array of lane contents plus the sticky error bit.
    logic [WIDTH-1:0] model [LANES];
    int               cur_act = 0;
    logic             model_err = 1'b0;

    block_select_buffer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .lanes_active (lanes_active),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_data     (msg_data),
        .par_valid    (par_valid),
        .par_ready    (par_ready),
        .par_data     (par_data),
        .par_sel      (par_sel),
        .par_last     (par_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_blocks   (out_blocks),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rnd_blk();
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] fill_byte(input logic [7:0] b);
        logic [WIDTH-1:0] v;
        v = {(WIDTH/8){b}};
        return v;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] exp_out();
        logic [LANES*WIDTH-1:0] e;
        e = '0;
        for (int i = 0; i < LANES; i++)
            if (i < cur_act) e[i*WIDTH +: WIDTH] = model[i];
        return e;
    endfunction

    function automatic int first_diff(input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b);
        for (int i = 0; i < LANES; i++)
            if (a[i*WIDTH +: WIDTH] !== b[i*WIDTH +: WIDTH]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int act);
        lanes_active = LW'(act);
        start = 1'b1;
        step();
        start = 1'b0;
        if (act >= 1 && act <= LANES) begin
            cur_act   = act;
            model_err = 1'b0;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic load_msg(input int lane, input logic [WIDTH-1:0] d);
        int n = 0;
        while (!msg_ready && n < 50) begin step(); n++; end
        if (!msg_ready) begin
            vectors++; miscompares++;
            $display("FAIL load_timeout lane %0d msg_ready=%b required 1", lane, msg_ready);
        end
        msg_data  = d;
        msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        model[lane] = d;
    endtask

    task automatic load_all(input int act, input bit counting);
        do_start(act);
        for (int i = 0; i < act; i++) load_msg(i, counting ? WIDTH'(i + 1) : rnd_blk());
    endtask

    task automatic send_par(input logic [LANES-1:0] sel, input logic [LANES*WIDTH-1:0] d,
                            input logic last, input logic with_msg);
        int n = 0;
        while (!par_ready && n < 50) begin step(); n++; end
        if (!par_ready) begin
            vectors++; miscompares++;
            $display("FAIL par_timeout par_ready=%b required 1", par_ready);
        end
        par_sel   = sel;
        par_data  = d;
        par_last  = last;
        par_valid = 1'b1;
        msg_valid = with_msg;
        msg_data  = rnd_blk();
        step();
        par_valid = 1'b0;
        par_last  = 1'b0;
        msg_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i] && i < cur_act) model[i] = d[i*WIDTH +: WIDTH];
            if (sel[i] && i >= cur_act) model_err = 1'b1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, msg_ready, par_ready, out_valid, err} !== 5'b0 || out_blocks !== '0) begin
            miscompares++;
            $display("FAIL reset_state got busy/mr/pr/ov/err=%b outz=%b required 00000/1",
                     {busy, msg_ready, par_ready, out_valid, err}, out_blocks == '0);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_update();
        logic [LANES*WIDTH-1:0] d, e;
        load_all(22, 1'b1);
        vectors++;
        if (par_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_bubble par_ready=%b required 1", par_ready);
        end
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = fill_byte(8'hAA);
        send_par(23'h000005, d, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_out_valid got %b required 1", out_valid);
        end
        e = '0;
        for (int i = 0; i < 22; i++) e[i*WIDTH +: WIDTH] = (i == 0 || i == 2) ? fill_byte(8'hAA) : WIDTH'(i + 1);
        vectors++;
        if (out_blocks !== e) begin
            miscompares++;
            $display("FAIL lu_blocks lane %0d got %h required %h", first_diff(out_blocks, e),
                     out_blocks[first_diff(out_blocks, e)*WIDTH +: WIDTH], e[first_diff(out_blocks, e)*WIDTH +: WIDTH]);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_err got %b required 0", err);
        end
        drain();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_return_idle out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_same_lane();
        logic [LANES*WIDTH-1:0] d;
        load_all(5, 1'b0);
        for (int v = 5; v <= 7; v++) begin
            d = '0;
            d[3*WIDTH +: WIDTH] = WIDTH'(v);
            send_par(23'h000008, d, v == 7, 1'b0);
            vectors++;
            if (out_valid !== (v == 7)) begin
                miscompares++;
                $display("FAIL same_lane_valid update %0d got %b required %b", v, out_valid, v == 7);
            end
        end
        vectors++;
        if (out_blocks[3*WIDTH +: WIDTH] !== WIDTH'(7) || out_blocks !== exp_out()) begin
            miscompares++;
            $display("FAIL same_lane_value got %h required %h", out_blocks[3*WIDTH +: WIDTH], WIDTH'(7));
        end
        drain();
    endtask

    task automatic test_hold();
        logic [LANES*WIDTH-1:0] d, e;
        load_all(LANES, 1'b0);
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = rnd_blk();
        send_par(LANES'($urandom()), d, 1'b1, 1'b0);
        e = exp_out();
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            lanes_active = LW'(3);
            step();
            vectors++;
            if (out_blocks !== e || out_valid !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold cycle %0d ov=%b busy=%b lane %0d got %h required %h", c, out_valid, busy,
                         first_diff(out_blocks, e), out_blocks[first_diff(out_blocks, e)*WIDTH +: WIDTH],
                         e[first_diff(out_blocks, e)*WIDTH +: WIDTH]);
            end
        end
        start = 1'b0;
        drain();
        vectors++;
        if (busy !== 1'b0 || msg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release busy=%b msg_ready=%b required 0 0", busy, msg_ready);
        end
    endtask

    task automatic test_err_oob();
        logic [LANES*WIDTH-1:0] d;
        load_all(10, 1'b0);
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = rnd_blk();
        send_par(23'h008004, d, 1'b0, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_err_set got %b required 1", err);
        end
        send_par('0, d, 1'b1, 1'b0);
        vectors++;
        if (out_blocks[15*WIDTH +: WIDTH] !== '0 || out_blocks !== exp_out()) begin
            miscompares++;
            $display("FAIL oob_lane15 got %h required 0", out_blocks[15*WIDTH +: WIDTH]);
        end
        drain();
        vectors++;
        if (err !== model_err) begin
            miscompares++;
            $display("FAIL oob_err_sticky got %b required %b", err, model_err);
        end
        do_start(3);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_err_clear got %b required 0", err);
        end
        for (int i = 0; i < 3; i++) load_msg(i, rnd_blk());
        send_par('0, d, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_bad_start();
        do_start(0);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_start_zero busy=%b err=%b required 0 1", busy, err);
        end
        msg_valid = 1'b1;
        msg_data  = rnd_blk();
        step();
        msg_valid = 1'b0;
        vectors++;
        if (msg_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_start_msg msg_ready=%b busy=%b required 0 0", msg_ready, busy);
        end
        do_start(LANES + 1);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_start_over busy=%b err=%b required 0 1", busy, err);
        end
    endtask

    task automatic test_reset_mid_update();
        logic [LANES*WIDTH-1:0] d;
        load_all(4, 1'b0);
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = rnd_blk();
        send_par(23'h400001, d, 1'b0, 1'b0);
        par_valid = 1'b1;
        par_last  = 1'b1;
        par_sel   = '1;
        rst = 1'b1;
        step();
        vectors++;
        if ({busy, par_ready, out_valid, err} !== 4'b0 || out_blocks !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_update busy/pr/ov/err=%b required 0000", {busy, par_ready, out_valid, err});
        end
        rst = 1'b0;
        par_valid = 1'b0;
        par_last  = 1'b0;
        par_sel   = '0;
        step();
    endtask

    task automatic test_random();
        logic [LANES*WIDTH-1:0] d, e;
        logic [LANES-1:0] sel;
        int n_upd;
        for (int it = 0; it < 8; it++) begin
            load_all(int'($urandom_range(1, LANES)), 1'b0);
            n_upd = int'($urandom_range(1, 4));
            for (int u = 0; u < n_upd; u++) begin
                repeat ($urandom_range(0, 2)) step();
                for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = rnd_blk();
                sel = LANES'($urandom());
                if ($urandom_range(0, 3) != 0) sel = sel & LANES'((64'd1 << cur_act) - 1);
                send_par(sel, d, u == n_upd - 1, 1'($urandom()));
            end
            e = exp_out();
            vectors++;
            if (out_valid !== 1'b1 || out_blocks !== e || err !== model_err) begin
                miscompares++;
                $display("FAIL random it %0d act %0d ov=%b err=%b(req %b) lane %0d got %h required %h", it, cur_act,
                         out_valid, err, model_err, first_diff(out_blocks, e),
                         out_blocks[first_diff(out_blocks, e)*WIDTH +: WIDTH], e[first_diff(out_blocks, e)*WIDTH +: WIDTH]);
            end
            repeat ($urandom_range(0, 3)) step();
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_load_update();
        test_same_lane();
        test_hold();
        test_err_oob();
        test_bad_start();
        test_reset_mid_update();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
